pio_isr_rxfifo: RTL and testbench
=================================

Name: pio_isr_rxfifo

Overview:
Parametrised input shift register (ISR) with autopush and an integrated RX FIFO for the PIO state machine. It widens and generalises the single-ISR design: shift width, threshold and FIFO depth are set by parameters. It adds PUSH instruction semantics (iffull, block/noblock), autopush on threshold, stall generation and a FIFO join mode that doubles depth. It sits between the PIO execute stage and the system-bus RX read port.

Parameters:
DATA_W, 32, ISR and FIFO word width; power of two, 8..32
DEPTH, 4, RX FIFO depth in normal mode; joined mode gives 2*DEPTH; power of two
SW, $clog2(DATA_W), width of shift and threshold fields (derived; not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
penable  in  1  PIO clock-divider enable
stalled  in  1  external stall from other SM sources
din  in  DATA_W  shift/set source data
shift  in  SW  shift amount; 0 means DATA_W
dir  in  1  1=shift right, 0=shift left
set  in  1  load ISR from din, count from bit_count
bit_count  in  SW+1  count loaded by set
do_shift  in  1  IN instruction shift
do_push  in  1  PUSH instruction
push_iffull  in  1  PUSH is a no-op if count < threshold
push_block  in  1  PUSH stalls when FIFO full (0 = drop)
auto_push  in  1  autopush enable
thresh  in  SW  push threshold; 0 means DATA_W
join  in  1  use 2*DEPTH storage
rx_pop  in  1  bus-side read strobe
rx_data  out  DATA_W  FIFO head (first-word fall-through); 0 when empty
rx_empty  out  1  FIFO empty
rx_full  out  1  FIFO full at current depth
rx_level  out  $clog2(2*DEPTH)+1  occupancy
isr_dout  out  DATA_W  current ISR contents
shift_count  out  SW+1  early count = min(count+shift_eff, DATA_W)
stall  out  1  combinational; push blocked by a full FIFO

Behaviour:
- step = penable && !stalled && !stall. The ISR and count update only on step.
- shift_eff and thresh_eff are the 0->DATA_W decoded values. din is masked to its low shift_eff bits.
- Left shift: (isr<<s) | masked_din. Right shift: (isr>>s) | (masked_din<<(DATA_W-s)). The s=DATA_W case is handled explicitly, with no out-of-range Verilog shifts.
- Count saturates at DATA_W. new_count = min(count+shift_eff, DATA_W).
- Priority: set > do_push > do_shift.
- set: isr<=din, count<=bit_count. No push occurs.
- do_shift without autopush trigger: isr<=shifted value, count<=new_count.
- Autopush: auto_push && do_shift && new_count>=thresh_eff.
  - Writes the shifted value to the FIFO, then isr<=0, count<=0.
  - If the FIFO is full: stall=1, no state change. The operation retries each cycle.
- do_push:
  - If push_iffull && count<thresh_eff: no-op, stall=0.
  - Else if FIFO full and push_block: stall=1, ISR held.
  - Else if FIFO full and !push_block: data dropped, isr<=0, count<=0.
  - Else: write isr to FIFO, isr<=0, count<=0.
- Full is evaluated before any same-cycle pop: a push into a full FIFO stalls even if rx_pop is high. It succeeds next cycle.
- FIFO:
  - rx_pop is independent of penable and stalled.
  - Pop when empty is ignored.
  - A simultaneous push and pop with the FIFO not full keeps the level unchanged.
  - Pointers wrap modulo the current depth.
- A change of join (registered copy compared with input) flushes the FIFO: level 0, pointers 0, same cycle. Any push in that cycle is discarded; a blocking push stalls one cycle.
- Latency:
  - A write is visible on rx_data/rx_empty the cycle after the push edge.
  - shift_count is combinational, zero-cycle.
- Reset, including mid-operation: isr_dout=0, count=0, FIFO empty, rx_data=0, rx_level=0, rx_full=0, rx_empty=1. stall=0 once reset is deasserted.

Decomposition:
- Package pio_pkg:
  - SHIFT_LEFT/SHIFT_RIGHT constants
  - clog2 helper
  - decode function for 0->DATA_W fields
- Sub-module pio_rx_fifo:
  - parameters DATA_W and DEPTH, with 2*DEPTH storage
  - ports: push, pop, join, flush, data, empty, full, level
- The top level holds the ISR, count, push/stall logic and join-change detection.

Test Plan:
- Left shift with shift=8 ×4, din=0xA5,0x5A,0xFF,0x00, no autopush -> isr_dout=0xA55AFF00, shift_count=32 on the 4th cycle (saturated), FIFO empty.
- Right shift with shift=0, din=0xDEADBEEF -> isr_dout=0xDEADBEEF, count=32.
- Autopush thresh=16, right shift 8, din=0x11 then 0x22 -> FIFO receives 0x22110000, isr_dout=0, count=0, rx_level=1 next cycle.
- Four PUSHes of 0x1..0x4 (DEPTH=4), then a 5th blocking PUSH of 0x5:
  - stall=1 and isr held at 0x5.
  - rx_pop returns 0x1. The next cycle the push completes, rx_level=4.
  - A noblock repeat on a full FIFO drops the data and clears the ISR.
- join=1: 8 pushes accepted, 9th stalls. Toggle join to 0 -> rx_empty=1, rx_level=0 next cycle.
- push_iffull with count=8, thresh=32 -> no-op, ISR unchanged. Assert reset mid-stall -> all outputs reach their reset values on the next edge.

Source files
------------

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared constants and helpers for the PIO ISR / RX FIFO slice
package pio_pkg;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Shift/threshold fields encode the full word width as 0.
  function automatic int unsigned decode_field(input int unsigned v, input int unsigned full_val);
    return (v == 0) ? full_val : v;
  endfunction

endpackage

// File: rtl/pio_rx_fifo.sv
// rtl/pio_rx_fifo.sv - first-word fall-through RX FIFO with 2*DEPTH storage
// Normal mode uses DEPTH entries; join mode uses all 2*DEPTH entries.
module pio_rx_fifo
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      join_i,
  input  logic                      flush_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [$clog2(2*DEPTH):0]  level_o
);

  localparam int PW = clog2(2 * DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0] mem_q [2*DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     depth_cur;
  logic [PW-1:0]     last_idx;
  logic              do_push, do_pop;

  assign depth_cur = join_i ? LW'(2 * DEPTH) : LW'(DEPTH);
  assign last_idx  = PW'(depth_cur - LW'(1));
  assign full_o    = (level_q == depth_cur);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rdata_o   = empty_o ? '0 : mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == last_idx) ? '0 : wr_q + PW'(1);
      if (do_pop)  rd_q <= (rd_q == last_idx) ? '0 : rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i && do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/pio_isr_rxfifo.sv
// rtl/pio_isr_rxfifo.sv - PIO input shift register with autopush, PUSH and RX FIFO
// Holds the ISR, saturating bit count, push/stall decision and join-change flush.
module pio_isr_rxfifo
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int SW    = $clog2(DATA_W)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      penable_i,
  input  logic                      stalled_i,
  input  logic [DATA_W-1:0]         din_i,
  input  logic [SW-1:0]             shift_i,
  input  logic                      dir_i,
  input  logic                      set_i,
  input  logic [SW:0]               bit_count_i,
  input  logic                      do_shift_i,
  input  logic                      do_push_i,
  input  logic                      push_iffull_i,
  input  logic                      push_block_i,
  input  logic                      auto_push_i,
  input  logic [SW-1:0]             thresh_i,
  input  logic                      join_i,
  input  logic                      rx_pop_i,
  output logic [DATA_W-1:0]         rx_data_o,
  output logic                      rx_empty_o,
  output logic                      rx_full_o,
  output logic [$clog2(2*DEPTH):0]  rx_level_o,
  output logic [DATA_W-1:0]         isr_dout_o,
  output logic [SW:0]               shift_count_o,
  output logic                      stall_o
);

  localparam int CW = SW + 1;

  logic [DATA_W-1:0] isr_q, isr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              join_q;

  logic [CW-1:0]     shift_eff, thresh_eff, inv_shift, new_count;
  logic [CW:0]       count_sum;
  logic [DATA_W-1:0] din_mask, din_m, shifted;
  logic              en, join_chg, fifo_full, fifo_busy;
  logic              fifo_push, stall;
  logic [DATA_W-1:0] fifo_wdata;

  assign shift_eff  = CW'(decode_field(32'(shift_i), DATA_W));
  assign thresh_eff = CW'(decode_field(32'(thresh_i), DATA_W));
  assign inv_shift  = CW'(DATA_W) - shift_eff;
  assign din_mask   = {DATA_W{1'b1}} >> inv_shift;
  assign din_m      = din_i & din_mask;

  // A full-width shift replaces the ISR outright; smaller shifts stay in range.
  always_comb begin
    shifted = din_m;
    if (shift_eff != CW'(DATA_W)) begin
      if (dir_i == SHIFT_RIGHT) shifted = (isr_q >> shift_eff) | (din_m << inv_shift);
      else                      shifted = (isr_q << shift_eff) | din_m;
    end
  end

  assign count_sum = {1'b0, count_q} + {1'b0, shift_eff};
  assign new_count = (count_sum > (CW+1)'(DATA_W)) ? CW'(DATA_W) : count_sum[CW-1:0];

  assign en        = penable_i && !stalled_i;
  assign join_chg  = (join_i != join_q);
  assign fifo_busy = fifo_full || join_chg;

  always_comb begin
    isr_d      = isr_q;
    count_d    = count_q;
    stall      = 1'b0;
    fifo_push  = 1'b0;
    fifo_wdata = isr_q;
    if (en) begin
      if (set_i) begin
        isr_d   = din_i;
        count_d = bit_count_i;
      end else if (do_push_i) begin
        if (push_iffull_i && (count_q < thresh_eff)) begin
          isr_d = isr_q;
        end else if (fifo_busy && push_block_i) begin
          stall = 1'b1;
        end else begin
          fifo_push = !fifo_busy;
          isr_d     = '0;
          count_d   = '0;
        end
      end else if (do_shift_i) begin
        if (auto_push_i && (new_count >= thresh_eff)) begin
          if (fifo_busy) begin
            stall = 1'b1;
          end else begin
            fifo_push  = 1'b1;
            fifo_wdata = shifted;
            isr_d      = '0;
            count_d    = '0;
          end
        end else begin
          isr_d   = shifted;
          count_d = new_count;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      isr_q   <= '0;
      count_q <= '0;
      join_q  <= join_i;
    end else begin
      isr_q   <= isr_d;
      count_q <= count_d;
      join_q  <= join_i;
    end
  end

  pio_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (rx_pop_i),
    .join_i  (join_i),
    .flush_i (join_chg),
    .wdata_i (fifo_wdata),
    .rdata_o (rx_data_o),
    .empty_o (rx_empty_o),
    .full_o  (fifo_full),
    .level_o (rx_level_o)
  );

  assign rx_full_o     = fifo_full;
  assign isr_dout_o    = isr_q;
  assign shift_count_o = new_count;
  assign stall_o       = stall;

endmodule

// File: tb/tb_pio_isr_rxfifo.sv
// tb/tb_pio_isr_rxfifo.sv - queue-based reference model plus directed vectors for pio_isr_rxfifo
module tb_pio_isr_rxfifo;

  logic        clk = 1'b0;
  logic        reset, penable, stalled, dir, set, do_shift, do_push;
  logic        push_iffull, push_block, auto_push, jn, rx_pop;
  logic [31:0] din;
  logic [4:0]  shift, thresh;
  logic [5:0]  bit_count;
  logic [31:0] rx_data, isr_dout;
  logic        rx_empty, rx_full, stall;
  logic [3:0]  rx_level;
  logic [5:0]  shift_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  bit [31:0] m_isr;
  int        m_cnt;
  bit [31:0] m_q[$];
  bit        m_jprev;

  always #5 clk = ~clk;

  pio_isr_rxfifo #(.DATA_W(32), .DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset), .penable_i(penable), .stalled_i(stalled),
    .din_i(din), .shift_i(shift), .dir_i(dir), .set_i(set), .bit_count_i(bit_count),
    .do_shift_i(do_shift), .do_push_i(do_push), .push_iffull_i(push_iffull),
    .push_block_i(push_block), .auto_push_i(auto_push), .thresh_i(thresh),
    .join_i(jn), .rx_pop_i(rx_pop), .rx_data_o(rx_data), .rx_empty_o(rx_empty),
    .rx_full_o(rx_full), .rx_level_o(rx_level), .isr_dout_o(isr_dout),
    .shift_count_o(shift_count), .stall_o(stall)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 32 : v;
  endfunction

  function automatic int exp_shift_count();
    int c;
    c = m_cnt + eff(int'(shift));
    return (c > 32) ? 32 : c;
  endfunction

  function automatic void model_eval(output bit st, output bit wr, output bit [31:0] wd,
                                     output bit [31:0] ni, output int nc);
    longint unsigned wide, md, sh;
    int s, t, cap, nsh;
    bit busy;
    s    = eff(int'(shift));
    t    = eff(int'(thresh));
    wide = 64'(m_isr);
    md   = 64'(din) & ((64'd1 << s) - 1);
    if (dir) sh = ((wide >> s) | (md << (32 - s))) & 64'hFFFF_FFFF;
    else     sh = ((wide << s) | md) & 64'hFFFF_FFFF;
    nsh  = exp_shift_count();
    cap  = jn ? 8 : 4;
    busy = (m_q.size() >= cap) || (jn != m_jprev);
    st = 0; wr = 0; wd = 0; ni = m_isr; nc = m_cnt;
    if (!(penable && !stalled)) return;
    if (set) begin
      ni = din; nc = int'(bit_count);
    end else if (do_push) begin
      if (push_iffull && m_cnt < t) begin
        ni = m_isr;
      end else if (busy) begin
        if (push_block) st = 1;
        else begin ni = 0; nc = 0; end
      end else begin
        wr = 1; wd = m_isr; ni = 0; nc = 0;
      end
    end else if (do_shift) begin
      if (auto_push && nsh >= t) begin
        if (busy) st = 1;
        else begin wr = 1; wd = 32'(sh); ni = 0; nc = 0; end
      end else begin
        ni = 32'(sh); nc = nsh;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit st, wr;
    bit [31:0] wd, ni;
    int nc;
    if (reset) begin
      m_isr = 0; m_cnt = 0; m_q.delete(); m_jprev = jn;
    end else begin
      model_eval(st, wr, wd, ni, nc);
      if (jn != m_jprev) m_q.delete();
      else begin
        if (rx_pop && m_q.size() > 0) void'(m_q.pop_front());
        if (wr) m_q.push_back(wd);
      end
      m_isr = ni; m_cnt = nc; m_jprev = jn;
    end
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    bit st, wr;
    bit [31:0] wd, ni;
    int nc;
    if (chk_on) begin
      model_eval(st, wr, wd, ni, nc);
      check("isr_dout", 64'(isr_dout), 64'(m_isr));
      check("shift_count", 64'(shift_count), 64'(exp_shift_count()));
      if (!reset) check("stall", 64'(stall), 64'(st));
      check("rx_data", 64'(rx_data), (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
      check("rx_empty", 64'(rx_empty), 64'(m_q.size() == 0));
      check("rx_full", 64'(rx_full), 64'(m_q.size() == (jn ? 8 : 4)));
      check("rx_level", 64'(rx_level), 64'(m_q.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set = 0; do_shift = 0; do_push = 0; push_iffull = 0; push_block = 0;
    auto_push = 0; rx_pop = 0; din = 0; bit_count = 0;
  endtask

  task automatic load(input logic [31:0] v);
    idle(); set = 1; din = v; bit_count = 6'd8;
    tick();
  endtask

  task automatic push_word(input logic [31:0] v);
    load(v);
    idle(); do_push = 1; push_block = 1;
    tick();
  endtask

  initial begin
    logic [31:0] lshift_vec [4];
    lshift_vec[0] = 32'hA5; lshift_vec[1] = 32'h5A; lshift_vec[2] = 32'hFF; lshift_vec[3] = 32'h00;
    idle();
    reset = 1; penable = 1; stalled = 0; dir = 0; shift = 0; thresh = 0; jn = 0;
    tick(); tick();
    reset = 0;
    tick();
    check("lit_reset_isr", 64'(isr_dout), 64'h0);
    check("lit_reset_empty", 64'(rx_empty), 64'h1);
    check("lit_reset_level", 64'(rx_level), 64'h0);
    check("lit_reset_stall", 64'(stall), 64'h0);

    // Left shift by 8, four bytes, no autopush
    dir = 0; shift = 5'd8;
    for (int i = 0; i < 4; i++) begin
      idle(); do_shift = 1; din = lshift_vec[i];
      #1;
      if (i == 3) check("lit_lshift_count_sat", 64'(shift_count), 64'd32);
      tick();
    end
    check("lit_lshift_isr", 64'(isr_dout), 64'hA55AFF00);
    check("lit_lshift_empty", 64'(rx_empty), 64'h1);

    // Right shift, full width
    idle(); dir = 1; shift = 5'd0; do_shift = 1; din = 32'hDEADBEEF;
    tick();
    check("lit_rshift_full", 64'(isr_dout), 64'hDEADBEEF);
    check("lit_rshift_count", 64'(shift_count), 64'd32);

    // Autopush at threshold 16
    idle(); set = 1; din = 0; bit_count = 0;
    tick();
    idle(); shift = 5'd8; thresh = 5'd16; auto_push = 1; do_shift = 1; din = 32'h11;
    tick();
    din = 32'h22;
    tick();
    check("lit_autopush_data", 64'(rx_data), 64'h22110000);
    check("lit_autopush_isr", 64'(isr_dout), 64'h0);
    check("lit_autopush_level", 64'(rx_level), 64'd1);
    idle(); rx_pop = 1;
    tick();

    // Fill normal-depth FIFO, then blocking PUSH into full
    for (int v = 1; v <= 4; v++) push_word(32'(v));
    load(32'h5);
    idle(); do_push = 1; push_block = 1;
    #1 check("lit_full_stall", 64'(stall), 64'h1);
    tick();
    check("lit_full_isr_held", 64'(isr_dout), 64'h5);
    check("lit_full_level", 64'(rx_level), 64'd4);
    rx_pop = 1;
    #1 check("lit_pop_head", 64'(rx_data), 64'h1);
    check("lit_stall_with_pop", 64'(stall), 64'h1);
    tick();
    rx_pop = 0;
    #1 check("lit_stall_released", 64'(stall), 64'h0);
    tick();
    check("lit_retry_level", 64'(rx_level), 64'd4);
    check("lit_retry_isr", 64'(isr_dout), 64'h0);
    load(32'h6);
    idle(); do_push = 1; push_block = 0;
    #1 check("lit_noblock_stall", 64'(stall), 64'h0);
    tick();
    check("lit_noblock_isr", 64'(isr_dout), 64'h0);
    check("lit_noblock_level", 64'(rx_level), 64'd4);
    idle(); rx_pop = 1;
    for (int i = 0; i < 4; i++) tick();
    idle();

    // Join mode: 8 entries then stall, toggle back flushes
    jn = 1;
    tick();
    for (int v = 0; v < 8; v++) push_word(32'h100 + 32'(v));
    check("lit_join_full", 64'(rx_full), 64'h1);
    check("lit_join_level", 64'(rx_level), 64'd8);
    load(32'h9);
    idle(); do_push = 1; push_block = 1;
    #1 check("lit_join_stall", 64'(stall), 64'h1);
    tick();
    idle(); jn = 0;
    tick();
    check("lit_unjoin_empty", 64'(rx_empty), 64'h1);
    check("lit_unjoin_level", 64'(rx_level), 64'd0);

    // push_iffull below threshold
    load(32'hABC);
    idle(); thresh = 5'd0; do_push = 1; push_iffull = 1; push_block = 1;
    #1 check("lit_iffull_stall", 64'(stall), 64'h0);
    tick();
    check("lit_iffull_isr", 64'(isr_dout), 64'hABC);
    check("lit_iffull_level", 64'(rx_level), 64'd0);

    // Reset in the middle of a blocked push
    for (int v = 0; v < 4; v++) push_word(32'h10 + 32'(v));
    load(32'h77);
    idle(); do_push = 1; push_block = 1;
    #1 check("lit_pre_reset_stall", 64'(stall), 64'h1);
    reset = 1;
    tick();
    check("lit_rst_isr", 64'(isr_dout), 64'h0);
    check("lit_rst_level", 64'(rx_level), 64'd0);
    check("lit_rst_empty", 64'(rx_empty), 64'h1);
    check("lit_rst_full", 64'(rx_full), 64'h0);
    check("lit_rst_data", 64'(rx_data), 64'h0);
    idle(); reset = 0;
    tick();
    check("lit_post_rst_stall", 64'(stall), 64'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
